// File: rtl/run_event_tracker.sv
// Tracks ones/zeros runs from a detector code and reports each finished run over valid/ready.
// All outputs registered (report one cycle after run end); a report ending while one is held unaccepted is dropped and flagged.
module run_event_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       det_in,
  input  logic             clr,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic             rpt_type,
  output logic [CNT_W-1:0] rpt_len,
  output logic [CNT_W-1:0] ones_events,
  output logic [CNT_W-1:0] zeros_events,
  output logic [CNT_W-1:0] longest_run,
  output logic             rpt_ovf,
  output logic             code_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_ONE  = 2'b01,
    RUN_ZERO = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] zeros_q, zeros_d;
  logic [CNT_W-1:0] longest_q, longest_d;
  logic [CNT_W-1:0] rpt_len_q, rpt_len_d;
  logic             rpt_vld_q, rpt_vld_d;
  logic             rpt_type_q, rpt_type_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [1:0]       code;
  logic             run_end;
  logic             end_type;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ones_d     = ones_q;
    zeros_d    = zeros_q;
    longest_d  = longest_q;
    rpt_len_d  = rpt_len_q;
    rpt_vld_d  = rpt_vld_q;
    rpt_type_d = rpt_type_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    run_end    = 1'b0;
    end_type   = 1'b0;
    // The illegal code behaves exactly like "no run" apart from the sticky flag.
    code       = (det_in == 2'b10) ? 2'b00 : det_in;

    if (clr) begin
      state_d    = IDLE;
      len_d      = '0;
      ones_d     = '0;
      zeros_d    = '0;
      longest_d  = '0;
      rpt_len_d  = '0;
      rpt_vld_d  = 1'b0;
      rpt_type_d = 1'b0;
      ovf_d      = 1'b0;
      err_d      = 1'b0;
    end else begin
      if (det_in == 2'b10) err_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (code == 2'b01) begin
            state_d = RUN_ONE;
            len_d   = CNT_ONE;
            ones_d  = sat_inc(ones_q);
          end else if (code == 2'b11) begin
            state_d = RUN_ZERO;
            len_d   = CNT_ONE;
            zeros_d = sat_inc(zeros_q);
          end
        end
        RUN_ONE: begin
          if (code == 2'b01) begin
            len_d = sat_inc(len_q);
          end else if (code == 2'b11) begin
            run_end  = 1'b1;
            end_type = 1'b0;
            state_d  = RUN_ZERO;
            len_d    = CNT_ONE;
            zeros_d  = sat_inc(zeros_q);
          end else begin
            run_end  = 1'b1;
            end_type = 1'b0;
            state_d  = IDLE;
            len_d    = '0;
          end
        end
        RUN_ZERO: begin
          if (code == 2'b11) begin
            len_d = sat_inc(len_q);
          end else if (code == 2'b01) begin
            run_end  = 1'b1;
            end_type = 1'b1;
            state_d  = RUN_ONE;
            len_d    = CNT_ONE;
            ones_d   = sat_inc(ones_q);
          end else begin
            run_end  = 1'b1;
            end_type = 1'b1;
            state_d  = IDLE;
            len_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          len_d   = '0;
        end
      endcase

      if (rpt_vld_q && rpt_ready) rpt_vld_d = 1'b0;

      // A slot freed by this edge's handshake can take the new report immediately.
      if (run_end) begin
        longest_d = (len_q > longest_q) ? len_q : longest_q;
        if (!rpt_vld_q || rpt_ready) begin
          rpt_vld_d  = 1'b1;
          rpt_type_d = end_type;
          rpt_len_d  = len_q;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      ones_q     <= '0;
      zeros_q    <= '0;
      longest_q  <= '0;
      rpt_len_q  <= '0;
      rpt_vld_q  <= 1'b0;
      rpt_type_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ones_q     <= ones_d;
      zeros_q    <= zeros_d;
      longest_q  <= longest_d;
      rpt_len_q  <= rpt_len_d;
      rpt_vld_q  <= rpt_vld_d;
      rpt_type_q <= rpt_type_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign rpt_valid    = rpt_vld_q;
  assign rpt_type     = rpt_type_q;
  assign rpt_len      = rpt_len_q;
  assign ones_events  = ones_q;
  assign zeros_events = zeros_q;
  assign longest_run  = longest_q;
  assign rpt_ovf      = ovf_q;
  assign code_err     = err_q;

endmodule

// File: tb/tb_run_event_tracker.sv
// Bench for run_event_tracker: directed scenarios plus randomized traffic against a run-level model.
module tb_run_event_tracker;

  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       rpt_ready = 1'b0;
  logic [1:0] det_in = 2'b00;

  logic       rpt_valid, rpt_type, rpt_ovf, code_err;
  logic [7:0] rpt_len, ones_events, zeros_events, longest_run;

  logic       s_rpt_valid, s_rpt_type, s_rpt_ovf, s_code_err;
  logic [3:0] s_rpt_len, s_ones_events, s_zeros_events, s_longest_run;

  run_event_tracker #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .det_in(det_in), .clr(clr),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_type(rpt_type), .rpt_len(rpt_len),
    .ones_events(ones_events), .zeros_events(zeros_events), .longest_run(longest_run),
    .rpt_ovf(rpt_ovf), .code_err(code_err)
  );

  run_event_tracker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .det_in(det_in), .clr(clr),
    .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready), .rpt_type(s_rpt_type), .rpt_len(s_rpt_len),
    .ones_events(s_ones_events), .zeros_events(s_zeros_events), .longest_run(s_longest_run),
    .rpt_ovf(s_rpt_ovf), .code_err(s_code_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: current run kind (0 none, 1 ones, 2 zeros) and length, plus a one-deep report slot.
  int m_run, m_len, m_ones, m_zeros, m_long, m_rlen;
  bit m_vld, m_type, m_ovf, m_err;

  wire [35:0] obs_vec = {rpt_valid, rpt_type, rpt_len, ones_events, zeros_events,
                         longest_run, rpt_ovf, code_err};

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic logic [35:0] exp_vec();
    return {m_vld, m_type, 8'(m_rlen), 8'(m_ones), 8'(m_zeros), 8'(m_long), m_ovf, m_err};
  endfunction

  task automatic model_clear();
    m_run = 0; m_len = 0; m_ones = 0; m_zeros = 0; m_long = 0; m_rlen = 0;
    m_vld = 0; m_type = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [1:0] d, input logic c, input logic r);
    int  code;
    bit  ended;
    bit  etype;
    int  elen;
    if (c) begin
      model_clear();
      return;
    end
    if (d == 2'b10) m_err = 1;
    code  = (d == 2'b01) ? 1 : (d == 2'b11) ? 2 : 0;
    ended = (m_run != 0) && (code != m_run);
    etype = (m_run == 2);
    elen  = m_len;
    if (m_vld && r) m_vld = 0;
    if (ended) begin
      if (elen > m_long) m_long = elen;
      if (!m_vld) begin
        m_vld = 1; m_type = etype; m_rlen = elen;
      end else begin
        m_ovf = 1;
      end
    end
    if (code == 0) begin
      m_run = 0; m_len = 0;
    end else if (code != m_run) begin
      m_run = code; m_len = 1;
      if (code == 1) m_ones = sat(m_ones + 1);
      else           m_zeros = sat(m_zeros + 1);
    end else begin
      m_len = sat(m_len + 1);
    end
  endtask

  task automatic cyc(input logic [1:0] d, input logic c, input logic r);
    det_in = d; clr = c; rpt_ready = r;
    @(posedge clk);
    model_step(d, c, r);
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (obs_vec !== 36'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", obs_vec);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_ones_run();
    for (int i = 0; i < 4; i++) cyc(2'b01, 1'b0, 1'b1);
    checks++;
    if (rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ones_open_run_no_report got v=%0b exp v=0", rpt_valid);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if ({rpt_valid, rpt_type, rpt_len, ones_events, longest_run} !== {1'b1, 1'b0, 8'd4, 8'd1, 8'd4}) begin
      failures++;
      $display("FAIL ones_report got v=%0b t=%0b l=%0d ones=%0d long=%0d exp v=1 t=0 l=4 ones=1 long=4",
               rpt_valid, rpt_type, rpt_len, ones_events, longest_run);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if (rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ones_pulse_width got v=%0b exp v=0", rpt_valid);
    end
  endtask

  task automatic test_direct_switch();
    cyc(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 1'b1);
    checks++;
    if ({rpt_valid, rpt_type, rpt_len} !== {1'b1, 1'b1, 8'd3}) begin
      failures++;
      $display("FAIL switch_first_report got v=%0b t=%0b l=%0d exp v=1 t=1 l=3", rpt_valid, rpt_type, rpt_len);
    end
    cyc(2'b01, 1'b0, 1'b1);
    checks++;
    if (rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL switch_gap got v=%0b exp v=0", rpt_valid);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if ({rpt_valid, rpt_type, rpt_len, ones_events, zeros_events, longest_run} !==
        {1'b1, 1'b0, 8'd2, 8'd1, 8'd1, 8'd3}) begin
      failures++;
      $display("FAIL switch_second_report got v=%0b t=%0b l=%0d ones=%0d zeros=%0d long=%0d exp 1 0 2 1 1 3",
               rpt_valid, rpt_type, rpt_len, ones_events, zeros_events, longest_run);
    end
  endtask

  task automatic test_backpressure();
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rpt_valid, rpt_type, rpt_len} !== {1'b1, 1'b0, 8'd2}) begin
        failures++;
        $display("FAIL bp_hold i=%0d got v=%0b t=%0b l=%0d exp v=1 t=0 l=2", i, rpt_valid, rpt_type, rpt_len);
      end
      cyc(2'b11, 1'b0, 1'b0);
    end
    cyc(2'b00, 1'b0, 1'b0);
    checks++;
    if ({rpt_valid, rpt_type, rpt_len, rpt_ovf, longest_run} !== {1'b1, 1'b0, 8'd2, 1'b1, 8'd5}) begin
      failures++;
      $display("FAIL bp_drop got v=%0b t=%0b l=%0d ovf=%0b long=%0d exp v=1 t=0 l=2 ovf=1 long=5",
               rpt_valid, rpt_type, rpt_len, rpt_ovf, longest_run);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if ({rpt_valid, rpt_ovf} !== 2'b01) begin
      failures++;
      $display("FAIL bp_consume got v=%0b ovf=%0b exp v=0 ovf=1", rpt_valid, rpt_ovf);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if (rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_second got v=%0b exp v=0", rpt_valid);
    end
  endtask

  task automatic test_saturation();
    cyc(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc(2'b11, 1'b0, 1'b1);
    checks++;
    if (s_rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_open_run got v=%0b exp v=0", s_rpt_valid);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if ({s_rpt_valid, s_rpt_type, s_rpt_len, s_longest_run, s_zeros_events} !==
        {1'b1, 1'b1, 4'd15, 4'd15, 4'd1}) begin
      failures++;
      $display("FAIL sat_report got v=%0b t=%0b l=%0d long=%0d zeros=%0d exp v=1 t=1 l=15 long=15 zeros=1",
               s_rpt_valid, s_rpt_type, s_rpt_len, s_longest_run, s_zeros_events);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL sat_wide_instance got=%h exp=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_illegal_clear();
    cyc(2'b00, 1'b1, 1'b1);
    cyc(2'b10, 1'b0, 1'b1);
    checks++;
    if ({code_err, rpt_valid, ones_events, zeros_events} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL illegal_code got err=%0b v=%0b ones=%0d zeros=%0d exp err=1 v=0 ones=0 zeros=0",
               code_err, rpt_valid, ones_events, zeros_events);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if ({code_err, rpt_valid} !== 2'b10) begin
      failures++;
      $display("FAIL illegal_stays_idle got err=%0b v=%0b exp err=1 v=0", code_err, rpt_valid);
    end
    cyc(2'b01, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 1'b1);
    cyc(2'b01, 1'b1, 1'b1);
    checks++;
    if (obs_vec !== 36'h0) begin
      failures++;
      $display("FAIL clear_all got=%h exp=0", obs_vec);
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if (rpt_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_report got v=%0b exp v=0", rpt_valid);
    end
  endtask

  task automatic test_async_reset();
    cyc(2'b00, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({obs_vec, s_rpt_valid} !== 37'h0) begin
      failures++;
      $display("FAIL async_reset got=%h sat_v=%0b exp all 0", obs_vec, s_rpt_valid);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 1'b0, 1'b1);
      checks++;
      if (rpt_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet i=%0d got v=%0b exp v=0", i, rpt_valid);
      end
    end
    cyc(2'b00, 1'b0, 1'b1);
    checks++;
    if ({rpt_valid, rpt_type, rpt_len, ones_events} !== {1'b1, 1'b0, 8'd3, 8'd1}) begin
      failures++;
      $display("FAIL post_reset_report got v=%0b t=%0b l=%0d ones=%0d exp v=1 t=0 l=3 ones=1",
               rpt_valid, rpt_type, rpt_len, ones_events);
    end
  endtask

  task automatic test_random();
    logic [1:0] d;
    logic       c;
    logic       r;
    int         sel;
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 15);
      d = (sel < 6) ? 2'b01 : (sel < 11) ? 2'b11 : (sel < 15) ? 2'b00 : 2'b10;
      c = ($urandom_range(0, 999) == 0);
      r = ($urandom_range(0, 3) != 0);
      cyc(d, c, r);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random n=%0d got=%h exp=%h", n, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones_run();
    test_direct_switch();
    test_backpressure();
    test_saturation();
    test_illegal_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_event_tracker.md
RUN_EVENT_TRACKER -- requirements
Module: run_event_tracker

Interface
REQ-001 Parameter CNT_W, default 8: width of every counter and length field.
REQ-002 clk  input  1  rising-edge clock; all state sampled here.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 det_in  input  2  detector output code: 00 none, 01 ones-run, 11 zeros-run, 10 illegal.
REQ-005 clr  input  1  synchronous clear of all state.
REQ-006 rpt_valid  output  1  run report available.
REQ-007 rpt_ready  input  1  consumer accepts report.
REQ-008 rpt_type  output  1  report type: 0 ones-run, 1 zeros-run.
REQ-009 rpt_len  output  CNT_W  report length in cycles.
REQ-010 ones_events  output  CNT_W  count of ones-runs started.
REQ-011 zeros_events  output  CNT_W  count of zeros-runs started.
REQ-012 longest_run  output  CNT_W  maximum completed run length, either type.
REQ-013 rpt_ovf  output  1  sticky: a report was dropped.
REQ-014 code_err  output  1  sticky: det_in = 10 was sampled.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, RUN_ONE, RUN_ZERO; all outputs registered.
REQ-016 Sampled det_in = 10 SHALL be treated as 00 and SHALL set code_err on the same edge.
REQ-017 IDLE: 01 -> RUN_ONE, 11 -> RUN_ZERO, else stay; on entry run length SHALL load 1.
REQ-018 RUN_ONE/RUN_ZERO: same code -> stay, run length +1 saturating at 2^CNT_W-1.
- RUN_ONE/RUN_ZERO, 00 (or 10) -> IDLE and the run ends.
REQ-019 A direct change 01<->11 SHALL end the current run and start the other in the same edge: new length = 1, new start counted.
REQ-020 On each run start, ones_events or zeros_events SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-021 On run end, a report {type, final length} SHALL be offered.
- rpt_valid asserts the cycle after the edge that sampled the ending code.
- The length counts the sampled cycles carrying the run code.
REQ-022 On run end, longest_run SHALL update to max(longest_run, final length) on the same edge that loads the report.
REQ-023 Handshake: rpt_type/rpt_len SHALL stay stable while rpt_valid=1 and rpt_ready=0.
- A report is consumed on an edge where rpt_valid=1 and rpt_ready=1.
- rpt_valid deasserts after that edge unless a new report loads.
REQ-024 Run end while the report register is empty, or on the same edge it is consumed: the new report SHALL load, nothing dropped.
REQ-025 Run end while rpt_valid=1 and rpt_ready=0: the new report SHALL be dropped, the held report kept, rpt_ovf set.
- longest_run SHALL still update.
REQ-026 An open run never reports until it ends; at saturation it keeps reporting 2^CNT_W-1.
REQ-027 clr=1 SHALL override all other activity on that edge:
- FSM -> IDLE, run length 0, all counters 0, longest_run 0.
- rpt_valid 0, rpt_ovf 0, code_err 0.
- det_in on that edge is ignored.

Reset
REQ-028 rst_n=0 SHALL immediately, without clk, force FSM IDLE and run length 0.
- All outputs go to 0: rpt_valid, rpt_type, rpt_len, ones_events, zeros_events, longest_run, rpt_ovf, code_err.
REQ-029 Reset asserted mid-run or with a report pending SHALL discard both; no report is emitted after release.
REQ-030 The first edge after rst_n rises SHALL sample det_in normally.

Verification
REQ-031 Ones-run report: det_in 01 for 4 cycles then 00, rpt_ready=1.
- rpt_valid pulses 1 cycle with type 0, len 4; ones_events=1; longest_run=4.
REQ-032 Direct switch: 11 x3, 01 x2, 00.
- Reports (1,3) then (0,2), each one cycle after its end.
- zeros_events=1, ones_events=1, longest_run=3.
REQ-033 Backpressure: rpt_ready=0; runs 01 x2, 00, 11 x5, 00.
- Report (0,2) held stable; second run dropped; rpt_ovf=1; longest_run=5.
- rpt_ready=1 then consumes (0,2) only.
REQ-034 Saturation, CNT_W=4: det_in 11 for 20 cycles then 00 -> report (1,15), longest_run=15.
REQ-035 Illegal and clear: det_in 10 for 1 cycle -> code_err=1, FSM stays IDLE, no counter change.
- clr=1 during a 01 run -> all outputs 0 next cycle; no report for the aborted run.
REQ-036 Async reset: rst_n=0 mid-cycle during a 01 run with a report pending -> all outputs 0 before the next clk edge.
- After release, det_in 01 x3, 00 -> single report (0,3).
